// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, downstream hold and a saturating bubble counter.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic [4:0]        id_dest_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              ex_valid_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_dest_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              valid_q, valid_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              haz;

    // Only a load (memread) in EX can create a hazard; $0 is never a real dependency.
    assign haz = valid_q & ctrl_q[1] & (dest_q != 5'd0) & id_valid_i &
                 ((dest_q == id_rs_i) | (id_uses_rt_i & (dest_q == id_rt_i)));

    // hold is gated so stall reads 0 while reset is asserted
    assign stall_o = haz | (hold_i & rst_n);

    always_comb begin
        valid_d   = valid_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        dest_d    = dest_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        if (flush_i || (!hold_i && haz)) begin
            valid_d   = 1'b0;
            rs_d      = '0;
            rt_d      = '0;
            dest_d    = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            ctrl_d    = '0;
            if (!flush_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else if (!hold_i) begin
            valid_d   = id_valid_i;
            rs_d      = id_rs_i;
            rt_d      = id_rt_i;
            dest_d    = id_dest_i;
            rs_data_d = id_rs_data_i;
            rt_data_d = id_rt_data_i;
            imm_d     = id_imm_i;
            ctrl_d    = id_valid_i ? id_ctrl_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dest_q    <= dest_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_valid_o   = valid_q;
    assign ex_rs_o      = rs_q;
    assign ex_rt_o      = rt_q;
    assign ex_dest_o    = dest_q;
    assign ex_rs_data_o = rs_data_q;
    assign ex_rt_data_o = rt_data_q;
    assign ex_imm_o     = imm_q;
    assign ex_ctrl_o    = ctrl_q;
    assign bubble_cnt_o = cnt_q;

endmodule
